lcd_driver: RTL and testbench
=============================

Name: lcd_driver

Overview:
Hardware writer for an HD44780-style character LCD. It is the consumer end of the CPU's LCD output port. The CPU hands over command and data bytes through a valid/ready handshake, and this block generates the power-up wait, the init sequence, and the RS/EN/DATA timing. It sits between the LSU output-peripheral register and the LCD pins, so software never bit-bangs EN.

Parameters:
SETUP_CYC, 2, cycles RS/DATA are stable before EN rises (min 1)
EN_HIGH_CYC, 25, cycles EN is held high (500 ns at 50 MHz)
CMD_WAIT_CYC, 2500, post-write wait for ordinary commands/data (50 us)
CLR_WAIT_CYC, 100000, post-write wait for clear/home, i.e. RS=0 and DATA in {0x01,0x02,0x03} (2 ms)
PWRUP_CYC, 1000000, wait after reset before the first LCD access (20 ms)

Ports:
clk        in   1   system clock
rst        in   1   asynchronous reset, active-high
req_vld    in   1   CPU has a byte to write
req_rs     in   1   0 = command, 1 = data
req_data   in   8   byte to write
req_rdy    out  1   block accepts a request this cycle
lcd_on_i   in   1   backlight/power request from the CPU register
lcd_data   out  8   LCD DB7..DB0
lcd_rs     out  1   LCD register select
lcd_rw     out  1   LCD read/write; always 0
lcd_en     out  1   LCD enable strobe
lcd_on     out  1   registered copy of lcd_on_i
busy       out  1   high whenever the block is not in IDLE
init_done  out  1   high once power-up and init are complete; sticky until rst

Behaviour:
- Reset (async, rst=1): every output is 0, FSM goes to PWRUP, counters clear. Reset mid-transfer aborts immediately with EN low.
- lcd_on updates one cycle after lcd_on_i, in every state.
- FSM states:
  - PWRUP: counts PWRUP_CYC cycles, then goes to INIT.
  - INIT: issues the ROM sequence 0x38, 0x0C, 0x01, 0x06 (RS=0) one entry at a time. Each entry goes through SETUP→PULSE→HOLD→WAIT, and the 0x01 entry uses CLR_WAIT_CYC.
  - IDLE: init_done=1 after the last INIT entry's WAIT. req_rdy = (state==IDLE) && init_done; it is combinational from state only, never from req_vld.
- Accept: on a cycle with req_vld && req_rdy, req_rs and req_data are captured; the next state is SETUP and req_rdy falls the following cycle.
- Per-write timing, with the accept edge at t=0:
  - SETUP: SETUP_CYC cycles with lcd_rs/lcd_data driven and lcd_en=0.
  - PULSE: EN_HIGH_CYC cycles with lcd_en=1.
  - HOLD: 1 cycle with lcd_en=0 and data still held.
  - WAIT: CMD_WAIT_CYC or CLR_WAIT_CYC cycles.
  - Then IDLE.
- Spacing between consecutive accepts is SETUP_CYC+EN_HIGH_CYC+1+WAIT+1 cycles.
- lcd_rs/lcd_data keep their last value in IDLE/WAIT; they change only on entry to SETUP.
- busy = (state != IDLE).
- req_vld asserted during PWRUP/INIT is ignored; it is not queued and no request is lost silently, because rdy=0.
- A request held with req_vld=1 back-to-back is accepted exactly once per IDLE visit.
- Counters are sized with $clog2 of the largest parameter + 1 and never wrap. The wait select is decided from the captured byte, not the live input.

Optional Feature:
- LCD_INIT_EN defined: PWRUP and the INIT sequence run as described above.
- LCD_INIT_EN undefined:
  - INIT is removed; PWRUP goes directly to IDLE and init_done rises when PWRUP ends.
  - Software is then responsible for sending the init commands.
  - All per-write timing is unchanged.

Decomposition:
- Package lcd_pkg holds:
  - the state enum (PWRUP, INIT, IDLE, SETUP, PULSE, HOLD, WAIT)
  - the LCD_CMD_* constants (FUNCSET 0x38, DISPON 0x0C, CLEAR 0x01, ENTRY 0x06)
  - the init ROM array and its length
  - an is_slow_cmd(rs, data) function
- One sub-module, lcd_timer:
  - a load/count-down timer taking a load value, load, and tick enable
  - produces done; shared by every timed state.

Test Plan:
(Parameters for all scenarios: SETUP=2, EN_HIGH=4, CMD_WAIT=8, CLR_WAIT=20, PWRUP=10, LCD_INIT_EN defined.)
- Release rst at t0 → rdy=0 and busy=1 for 10+4*(2+4+1)+3*(8+1)+(20+1) cycles. Four EN pulses of 4 cycles each with data 0x38, 0x0C, 0x01, 0x06 and rs=0, then init_done=1 and rdy=1.
- After init, req rs=1 data=0x41 → rdy low next cycle. lcd_data=0x41 and rs=1 two cycles before EN rises, EN high 4 cycles, rdy back after 2+4+1+8+1 = 16 cycles from the accept.
- req rs=0 data=0x01 → 20-cycle wait, rdy returns after 28 cycles. rs=1 data=0x01 → normal 16.
- req_vld held high with 3 different bytes presented on each accept → exactly 3 EN pulses with the matching bytes, spaced 16 cycles apart. req_vld during PWRUP → no EN pulse.
- Assert rst while lcd_en=1 → lcd_en and all outputs 0 in the same cycle (async), FSM restarts at PWRUP.
- Toggle lcd_on_i 0→1→0 at arbitrary times, including during PULSE → lcd_on follows with 1-cycle lag, and the write timing is unaffected.

Source files
------------

// File: rtl/lcd_pkg.sv
// lcd_pkg: shared types and constants for the HD44780-style LCD writer.
//   lcd_state_e  - writer FSM states
//   LCD_CMD_*    - init command bytes
//   INIT_ROM     - power-up command sequence, entry 0 issued first
//   is_slow_cmd  - selects the long post-write wait (clear/home)
//   max_u        - helper used to size the shared timer
package lcd_pkg;

  typedef enum logic [2:0] {
    StPwrup,
    StInit,
    StIdle,
    StSetup,
    StPulse,
    StHold,
    StWait
  } lcd_state_e;

  localparam logic [7:0] LCD_CMD_FUNCSET = 8'h38;
  localparam logic [7:0] LCD_CMD_DISPON  = 8'h0C;
  localparam logic [7:0] LCD_CMD_CLEAR   = 8'h01;
  localparam logic [7:0] LCD_CMD_ENTRY   = 8'h06;

  localparam int unsigned INIT_LEN = 4;

  // Packed so entry i is INIT_ROM[i]; the rightmost element is entry 0.
  localparam logic [INIT_LEN-1:0][7:0] INIT_ROM = {
    LCD_CMD_ENTRY, LCD_CMD_CLEAR, LCD_CMD_DISPON, LCD_CMD_FUNCSET
  };

  // Clear display (0x01) and return home (0x02/0x03) need the long wait.
  function automatic logic is_slow_cmd(input logic rs, input logic [7:0] data);
    return !rs && (data == 8'h01 || data == 8'h02 || data == 8'h03);
  endfunction

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/lcd_timer.sv
// lcd_timer: load/count-down timer shared by every timed writer state.
//   clk, rst  - clock, asynchronous active-high reset
//   load      - load load_val this cycle (has priority over counting)
//   load_val  - value to load; a state lasting N cycles loads N-1
//   tick      - count-down enable; the count stops at zero and never wraps
//   done      - count is zero
module lcd_timer #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         tick,
  output logic         done
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (tick && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign done = (cnt_q == '0);

endmodule

// File: rtl/lcd_driver.sv
// lcd_driver: HD44780-style character LCD writer fed by a valid/ready byte port.
// Generates the power-up wait, the optional init sequence and RS/EN/DATA timing.
//   clk, rst        - clock, asynchronous active-high reset
//   req_vld/req_rdy - request handshake; req_rdy depends on state only
//   req_rs          - 0 = command, 1 = data
//   req_data        - byte to write
//   lcd_on_i        - backlight/power request, registered onto lcd_on
//   lcd_data/rs/rw/en - LCD pins (rw tied low)
//   busy            - FSM not idle
//   init_done       - sticky once power-up (and init) finished
// Build option: define LCD_INIT_EN to run the built-in init sequence after
// power-up; otherwise power-up goes straight to idle and software sends init.
// PWRUP_CYC must be at least 2.
module lcd_driver
  import lcd_pkg::*;
#(
  parameter int unsigned SETUP_CYC    = 2,
  parameter int unsigned EN_HIGH_CYC  = 25,
  parameter int unsigned CMD_WAIT_CYC = 2500,
  parameter int unsigned CLR_WAIT_CYC = 100000,
  parameter int unsigned PWRUP_CYC    = 1000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_vld,
  input  logic       req_rs,
  input  logic [7:0] req_data,
  output logic       req_rdy,
  input  logic       lcd_on_i,
  output logic [7:0] lcd_data,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_en,
  output logic       lcd_on,
  output logic       busy,
  output logic       init_done
);

  localparam int unsigned MaxCyc = max_u(max_u(max_u(SETUP_CYC, EN_HIGH_CYC),
                                               max_u(CMD_WAIT_CYC, CLR_WAIT_CYC)),
                                         PWRUP_CYC);
  localparam int unsigned CntW = $clog2(MaxCyc) + 1;

  lcd_state_e      state_q, state_d;
  logic            armed_q, armed_d;
  logic            init_done_q, init_done_d;
  logic            rs_q, rs_d;
  logic [7:0]      data_q, data_d;
  logic            lcd_on_q;
  logic            tmr_load, tmr_done, tmr_tick;
  logic [CntW-1:0] tmr_val;

`ifdef LCD_INIT_EN
  localparam int unsigned IdxW = $clog2(INIT_LEN);
  logic [IdxW-1:0] idx_q, idx_d;
`endif

  lcd_timer #(
    .W(CntW)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .load    (tmr_load),
    .load_val(tmr_val),
    .tick    (tmr_tick),
    .done    (tmr_done)
  );

  assign tmr_tick = (state_q != StIdle);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StPwrup;
      armed_q     <= 1'b0;
      init_done_q <= 1'b0;
      rs_q        <= 1'b0;
      data_q      <= 8'h00;
      lcd_on_q    <= 1'b0;
`ifdef LCD_INIT_EN
      idx_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      armed_q     <= armed_d;
      init_done_q <= init_done_d;
      rs_q        <= rs_d;
      data_q      <= data_d;
      lcd_on_q    <= lcd_on_i;
`ifdef LCD_INIT_EN
      idx_q       <= idx_d;
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    armed_d     = armed_q;
    init_done_d = init_done_q;
    rs_d        = rs_q;
    data_d      = data_q;
    tmr_load    = 1'b0;
    tmr_val     = '0;
`ifdef LCD_INIT_EN
    idx_d       = idx_q;
`endif
    unique case (state_q)
      StPwrup: begin
        // The timer is idle out of reset; the first PWRUP cycle arms it, so
        // loading PWRUP_CYC-2 makes PWRUP last PWRUP_CYC cycles in total.
        if (!armed_q) begin
          armed_d  = 1'b1;
          tmr_load = 1'b1;
          tmr_val  = CntW'(PWRUP_CYC - 2);
        end else if (tmr_done) begin
`ifdef LCD_INIT_EN
          state_d = StInit;
          idx_d   = '0;
`else
          state_d     = StIdle;
          init_done_d = 1'b1;
`endif
        end
      end
      StInit: begin
`ifdef LCD_INIT_EN
        rs_d     = 1'b0;
        data_d   = INIT_ROM[idx_q];
        tmr_load = 1'b1;
        tmr_val  = CntW'(SETUP_CYC - 1);
        state_d  = StSetup;
`else
        state_d = StIdle;
`endif
      end
      StIdle: begin
        if (req_vld && req_rdy) begin
          rs_d     = req_rs;
          data_d   = req_data;
          tmr_load = 1'b1;
          tmr_val  = CntW'(SETUP_CYC - 1);
          state_d  = StSetup;
        end
      end
      StSetup: begin
        if (tmr_done) begin
          tmr_load = 1'b1;
          tmr_val  = CntW'(EN_HIGH_CYC - 1);
          state_d  = StPulse;
        end
      end
      StPulse: begin
        if (tmr_done) begin
          tmr_load = 1'b1;
          tmr_val  = '0;
          state_d  = StHold;
        end
      end
      StHold: begin
        if (tmr_done) begin
          // Wait length comes from the captured byte, not the live request.
          tmr_load = 1'b1;
          tmr_val  = is_slow_cmd(rs_q, data_q) ? CntW'(CLR_WAIT_CYC - 1)
                                               : CntW'(CMD_WAIT_CYC - 1);
          state_d  = StWait;
        end
      end
      StWait: begin
        if (tmr_done) begin
`ifdef LCD_INIT_EN
          if (!init_done_q) begin
            if (idx_q == IdxW'(INIT_LEN - 1)) begin
              state_d     = StIdle;
              init_done_d = 1'b1;
            end else begin
              idx_d   = idx_q + 1'b1;
              state_d = StInit;
            end
          end else begin
            state_d = StIdle;
          end
`else
          state_d = StIdle;
`endif
        end
      end
      default: state_d = StPwrup;
    endcase
  end

  assign req_rdy   = (state_q == StIdle) && init_done_q;
  assign lcd_data  = data_q;
  assign lcd_rs    = rs_q;
  assign lcd_rw    = 1'b0;
  assign lcd_en    = (state_q == StPulse);
  assign lcd_on    = lcd_on_q;
  // Masked by rst so every output reads 0 while reset is held.
  assign busy      = (state_q != StIdle) && !rst;
  assign init_done = init_done_q;

endmodule

// File: tb/tb_lcd_driver.sv
// tb_lcd_driver: directed self-checking bench for lcd_driver.
// Uses SETUP=2, EN_HIGH=4, CMD_WAIT=8, CLR_WAIT=20, PWRUP=10; expectations
// follow the LCD_INIT_EN setting of the build.
module tb_lcd_driver;

  localparam int unsigned SETUP   = 2;
  localparam int unsigned ENH     = 4;
  localparam int unsigned CMDW    = 8;
  localparam int unsigned CLRW    = 20;
  localparam int unsigned PWR     = 10;
  localparam int unsigned NORM_LEN = SETUP + ENH + 1 + CMDW;  // 15 busy samples
  localparam int unsigned SLOW_LEN = SETUP + ENH + 1 + CLRW;  // 27 busy samples
`ifdef LCD_INIT_EN
  localparam int unsigned INIT_BUSY   = PWR + 4 * (1 + SETUP + ENH + 1) + 3 * CMDW + CLRW;
  localparam int unsigned INIT_PULSES = 4;
`else
  localparam int unsigned INIT_BUSY   = PWR;
  localparam int unsigned INIT_PULSES = 0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_vld = 1'b0;
  logic       req_rs = 1'b0;
  logic [7:0] req_data = 8'h00;
  logic       req_rdy;
  logic       lcd_on_i = 1'b0;
  logic [7:0] lcd_data;
  logic       lcd_rs, lcd_rw, lcd_en, lcd_on, busy, init_done;

  int vectors = 0;
  int miscompares = 0;

  // EN pulse monitor, sampled on the falling edge.
  int         cyc = 0;
  logic       en_prev = 1'b0;
  int         run = 0;
  logic [7:0] rise_data[$];
  logic       rise_rs[$];
  int         len_q[$];

  always #5 clk = ~clk;

  lcd_driver #(
    .SETUP_CYC   (SETUP),
    .EN_HIGH_CYC (ENH),
    .CMD_WAIT_CYC(CMDW),
    .CLR_WAIT_CYC(CLRW),
    .PWRUP_CYC   (PWR)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req_vld  (req_vld),
    .req_rs   (req_rs),
    .req_data (req_data),
    .req_rdy  (req_rdy),
    .lcd_on_i (lcd_on_i),
    .lcd_data (lcd_data),
    .lcd_rs   (lcd_rs),
    .lcd_rw   (lcd_rw),
    .lcd_en   (lcd_en),
    .lcd_on   (lcd_on),
    .busy     (busy),
    .init_done(init_done)
  );

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (lcd_en && !en_prev) begin
      rise_data.push_back(lcd_data);
      rise_rs.push_back(lcd_rs);
      run = 1;
    end else if (lcd_en) begin
      run = run + 1;
    end
    if (!lcd_en && en_prev) len_q.push_back(run);
    en_prev = lcd_en;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      $error("compare %s", tag);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // Releases reset and follows power-up/init; optionally holds a request
  // during PWRUP, which must be neither accepted nor queued.
  task automatic run_init(input bit hold_vld);
    int n, bad, r0, l0;
    logic [7:0] rom [4];
    rom[0] = 8'h38; rom[1] = 8'h0C; rom[2] = 8'h01; rom[3] = 8'h06;
    r0 = rise_data.size();
    l0 = len_q.size();
    if (hold_vld) begin
      req_vld  = 1'b1;
      req_rs   = 1'b1;
      req_data = 8'h55;
    end
    rst = 1'b0;
    #1;
    n   = 0;
    bad = 0;
    while (busy && n < 400) begin
      if (req_rdy) bad++;
      if (hold_vld && n == 6) req_vld = 1'b0;
      n++;
      step();
    end
    req_vld = 1'b0;
    chk("init_busy_len", n, INIT_BUSY);
    chk("rdy_low_in_init", bad, 0);
    chk("init_done", {31'd0, init_done}, 1);
    chk("rdy_after_init", {31'd0, req_rdy}, 1);
    chk("init_pulse_cnt", rise_data.size() - r0, INIT_PULSES);
`ifdef LCD_INIT_EN
    for (int i = 0; i < 4; i++) begin
      if (r0 + i < rise_data.size()) begin
        chk($sformatf("init_data%0d", i), {24'd0, rise_data[r0+i]}, {24'd0, rom[i]});
        chk($sformatf("init_rs%0d", i), {31'd0, rise_rs[r0+i]}, 0);
      end
      if (l0 + i < len_q.size()) chk($sformatf("init_len%0d", i), len_q[l0+i], ENH);
    end
`endif
  endtask

  // One write from IDLE; optionally toggles lcd_on_i in the middle of PULSE.
  task automatic do_write(input logic rs, input logic [7:0] data, input int exp_len,
                          input bit toggle);
    int n, en_first, en_cnt, r0;
    logic [7:0] d0;
    logic rs0, newon;
    r0 = rise_data.size();
    req_vld  = 1'b1;
    req_rs   = rs;
    req_data = data;
    step();
    req_vld  = 1'b0;
    req_data = ~data;  // captured byte must not follow the live input
    chk("rdy_fall", {31'd0, req_rdy}, 0);
    n = 0; en_first = -1; en_cnt = 0; d0 = 8'h00; rs0 = 1'b0; newon = 1'b0;
    while (!req_rdy && n < 200) begin
      if (n == 0) begin d0 = lcd_data; rs0 = lcd_rs; end
      if (lcd_en && en_first < 0) en_first = n;
      if (lcd_en) en_cnt++;
      if (toggle && n == 3) begin
        newon    = ~lcd_on_i;
        lcd_on_i = newon;
        #1;
        chk("lcd_on_lag0", {31'd0, lcd_on}, {31'd0, ~newon});
      end
      if (toggle && n == 4) chk("lcd_on_lag1", {31'd0, lcd_on}, {31'd0, newon});
      n++;
      step();
    end
    chk($sformatf("busy_len_%0h_%0h", rs, data), n, exp_len);
    chk("setup_data", {24'd0, d0}, {24'd0, data});
    chk("setup_rs", {31'd0, rs0}, {31'd0, rs});
    chk("en_rise_idx", en_first, SETUP);
    chk("en_high_cnt", en_cnt, ENH);
    chk("pulse_cnt", rise_data.size() - r0, 1);
    chk("idle_data_held", {24'd0, lcd_data}, {24'd0, data});
  endtask

  initial begin
    int acc [3];
    int r0, w;
    logic [7:0] bytes [3];
    bytes[0] = 8'h30; bytes[1] = 8'h31; bytes[2] = 8'h32;

    step();
    chk("reset_outputs",
        {24'd0, lcd_data, lcd_rs, lcd_rw, lcd_en, lcd_on, busy, init_done, req_rdy}, 0);
    run_init(1'b0);

    // lcd_on 0 -> 1 while idle
    lcd_on_i = 1'b1;
    #1;
    chk("lcd_on_idle_lag0", {31'd0, lcd_on}, 0);
    step();
    chk("lcd_on_idle_lag1", {31'd0, lcd_on}, 1);

    do_write(1'b1, 8'h41, NORM_LEN, 1'b1);  // lcd_on 1 -> 0 during PULSE
    do_write(1'b0, 8'h01, SLOW_LEN, 1'b0);
    do_write(1'b1, 8'h01, NORM_LEN, 1'b0);
    do_write(1'b0, 8'h03, SLOW_LEN, 1'b0);
    do_write(1'b0, 8'h04, NORM_LEN, 1'b0);

    // req_vld held high: one accept per IDLE visit
    r0 = rise_data.size();
    req_vld = 1'b1;
    req_rs  = 1'b1;
    for (int k = 0; k < 3; k++) begin
      req_data = bytes[k];
      w = 0;
      while (!req_rdy && w < 100) begin w++; step(); end
      acc[k] = cyc;
      step();
    end
    req_vld = 1'b0;
    w = 0;
    while (!req_rdy && w < 100) begin w++; step(); end
    chk("b2b_pulse_cnt", rise_data.size() - r0, 3);
    chk("b2b_gap01", acc[1] - acc[0], NORM_LEN + 1);
    chk("b2b_gap12", acc[2] - acc[1], NORM_LEN + 1);
    for (int k = 0; k < 3; k++) begin
      if (r0 + k < rise_data.size())
        chk($sformatf("b2b_data%0d", k), {24'd0, rise_data[r0+k]}, {24'd0, bytes[k]});
    end

    // Reset while EN is high
    lcd_on_i = 1'b1;
    req_vld  = 1'b1;
    req_rs   = 1'b1;
    req_data = 8'h5A;
    step();
    req_vld = 1'b0;
    w = 0;
    while (!lcd_en && w < 50) begin w++; step(); end
    chk("en_high_before_rst", {31'd0, lcd_en}, 1);
    rst = 1'b1;
    #1;
    chk("rst_async_outputs",
        {24'd0, lcd_data, lcd_rs, lcd_rw, lcd_en, lcd_on, busy, init_done, req_rdy}, 0);
    step();
    step();
    chk("rst_held_outputs",
        {24'd0, lcd_data, lcd_rs, lcd_rw, lcd_en, lcd_on, busy, init_done, req_rdy}, 0);
    run_init(1'b1);
    chk("lcd_on_after_rst", {31'd0, lcd_on}, 1);
    do_write(1'b1, 8'h42, NORM_LEN, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
